// File: rtl/sy_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sy_pkg : shared types and constants for the sy pipeline (decode queue entry)
// Revision: 1.0
// ----------------------------------------------------------------------------
package sy_pkg;

  localparam int IWTH            = 32;
  localparam int AWTH            = 32;
  localparam int DEC_QUEUE_DEPTH = 4;
  localparam int DEC_W           = 2;

  typedef struct packed {
    logic [IWTH-1:0] instr;
    logic [AWTH-1:0] pc;
    logic [AWTH-1:0] npc;
    logic            is_c;
    logic            excp;
  } dec_entry_t;

endpackage : sy_pkg
`default_nettype wire

// File: rtl/sy_ppl_dec_queue_mem.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sy_ppl_dec_queue_mem : DEPTH x dec_entry_t register array, 1 write / DEQ_W async reads
// Revision: 1.0
// ----------------------------------------------------------------------------
module sy_ppl_dec_queue_mem
  import sy_pkg::*;
#(
  parameter int DEPTH = DEC_QUEUE_DEPTH,
  parameter int DEQ_W = DEC_W
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 wr_en_i,
  input  logic [$clog2(DEPTH)-1:0]             wr_addr_i,
  input  dec_entry_t                           wr_data_i,
  input  logic [DEQ_W-1:0][$clog2(DEPTH)-1:0]  rd_addr_i,
  output dec_entry_t [DEQ_W-1:0]               rd_data_o
);

  dec_entry_t r_mem [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (wr_en_i) begin
      r_mem[wr_addr_i] <= wr_data_i;
    end
  end

  for (genvar k = 0; k < DEQ_W; k++) begin : g_rd
    assign rd_data_o[k] = r_mem[rd_addr_i[k]];
  end

endmodule : sy_ppl_dec_queue_mem
`default_nettype wire

// File: rtl/sy_ppl_dec_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sy_ppl_dec_queue : in-order fetch-to-decode queue, 1 enqueue / up to DEQ_W dequeues
// Optional SY_DEC_QUEUE_PERF_EN adds saturating empty/full cycle counters.
// Revision: 1.0
// ----------------------------------------------------------------------------
module sy_ppl_dec_queue
  import sy_pkg::*;
#(
  parameter int DEPTH = DEC_QUEUE_DEPTH,
  parameter int DEQ_W = DEC_W
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         fet_dec__vld_i,
  output logic                         dec_fet__rdy_o,
  input  dec_entry_t                   fet_dec__data_i,
  output logic [DEQ_W-1:0]             dec_slot_vld_o,
  output dec_entry_t [DEQ_W-1:0]       dec_slot_data_o,
  input  logic [$clog2(DEQ_W+1)-1:0]   dec_deq_cnt_i,
  input  logic                         dec_stall_i,
  output logic [$clog2(DEPTH+1)-1:0]   dec_cnt_o
`ifdef SY_DEC_QUEUE_PERF_EN
  ,
  output logic [31:0]                  perf_empty_cyc_o,
  output logic [31:0]                  perf_full_cyc_o
`endif
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = $clog2(DEPTH+1);

  logic [c_PW-1:0]             r_rd_ptr;
  logic [c_PW-1:0]             r_wr_ptr;
  logic [c_CW-1:0]             r_count;
  logic                        w_enq;
  logic [c_CW-1:0]             w_deq_req;
  logic [c_CW-1:0]             w_deq;
  logic [DEQ_W-1:0][c_PW-1:0]  w_rd_addr;

  // Ready depends on registered occupancy only, so a full queue stays closed
  // for the cycle in which it is being drained.
  assign dec_fet__rdy_o = (r_count != c_CW'(DEPTH));
  assign w_enq          = fet_dec__vld_i && dec_fet__rdy_o && !flush_i;
  assign w_deq_req      = dec_stall_i ? '0 : c_CW'(dec_deq_cnt_i);
  assign w_deq          = (w_deq_req > r_count) ? r_count : w_deq_req;
  assign dec_cnt_o      = r_count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + c_PW'(1);
      end
      r_rd_ptr <= r_rd_ptr + w_deq[c_PW-1:0];
      r_count  <= r_count + c_CW'(w_enq) - w_deq;
    end
  end

  for (genvar k = 0; k < DEQ_W; k++) begin : g_slot
    assign w_rd_addr[k]      = r_rd_ptr + c_PW'(k);
    assign dec_slot_vld_o[k] = (c_CW'(k) < r_count) && !flush_i;
  end

  sy_ppl_dec_queue_mem #(
    .DEPTH (DEPTH),
    .DEQ_W (DEQ_W)
  ) u_mem (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (w_enq),
    .wr_addr_i (r_wr_ptr),
    .wr_data_i (fet_dec__data_i),
    .rd_addr_i (w_rd_addr),
    .rd_data_o (dec_slot_data_o)
  );

`ifdef SY_DEC_QUEUE_PERF_EN
  logic [31:0] r_perf_empty;
  logic [31:0] r_perf_full;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_perf_empty <= '0;
      r_perf_full  <= '0;
    end else begin
      if ((r_count == '0) && (r_perf_empty != '1)) begin
        r_perf_empty <= r_perf_empty + 32'd1;
      end
      if ((r_count == c_CW'(DEPTH)) && (r_perf_full != '1)) begin
        r_perf_full <= r_perf_full + 32'd1;
      end
    end
  end

  assign perf_empty_cyc_o = r_perf_empty;
  assign perf_full_cyc_o  = r_perf_full;
`endif

`ifndef SYNTHESIS
  // Consuming more slots than are valid is an upstream protocol error (clamped above).
  a_deq_overrun : assert property (@(posedge clk_i) disable iff (rst_i)
    (!flush_i && !dec_stall_i && (r_count != '0)) |-> (c_CW'(dec_deq_cnt_i) <= r_count));
`endif

endmodule : sy_ppl_dec_queue
`default_nettype wire

// File: tb/tb_sy_ppl_dec_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sy_ppl_dec_queue : directed table plus wrap/reset sequences for sy_ppl_dec_queue
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_sy_ppl_dec_queue;
  import sy_pkg::*;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  flush_i;
  logic                  fet_dec__vld_i;
  logic                  dec_fet__rdy_o;
  dec_entry_t            fet_dec__data_i;
  logic [DEC_W-1:0]      dec_slot_vld_o;
  dec_entry_t [DEC_W-1:0] dec_slot_data_o;
  logic [1:0]            dec_deq_cnt_i;
  logic                  dec_stall_i;
  logic [2:0]            dec_cnt_o;
`ifdef SY_DEC_QUEUE_PERF_EN
  logic [31:0]           perf_empty_cyc_o;
  logic [31:0]           perf_full_cyc_o;
`endif

  sy_ppl_dec_queue #(
    .DEPTH (4),
    .DEQ_W (2)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .fet_dec__vld_i  (fet_dec__vld_i),
    .dec_fet__rdy_o  (dec_fet__rdy_o),
    .fet_dec__data_i (fet_dec__data_i),
    .dec_slot_vld_o  (dec_slot_vld_o),
    .dec_slot_data_o (dec_slot_data_o),
    .dec_deq_cnt_i   (dec_deq_cnt_i),
    .dec_stall_i     (dec_stall_i),
    .dec_cnt_o       (dec_cnt_o)
`ifdef SY_DEC_QUEUE_PERF_EN
    ,
    .perf_empty_cyc_o (perf_empty_cyc_o),
    .perf_full_cyc_o  (perf_full_cyc_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        flush;
    logic        vld;
    logic [31:0] pc;
    logic [1:0]  deq;
    logic        stall;
    logic [2:0]  e_cnt;
    logic        e_rdy;
    logic [1:0]  e_vld;
    logic [31:0] e_pc0;
    logic [31:0] e_pc1;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  function automatic dec_entry_t mk(input logic [31:0] pc);
    dec_entry_t e;
    e.instr = {16'hC0DE, pc[15:0]};
    e.pc    = pc;
    e.npc   = pc + 32'd4;
    e.is_c  = pc[2];
    e.excp  = pc[3];
    return e;
  endfunction

  function automatic vec_t mkv(input logic f, input logic v, input logic [31:0] pc,
                               input logic [1:0] d, input logic s, input logic [2:0] c,
                               input logic r, input logic [1:0] vl,
                               input logic [31:0] p0, input logic [31:0] p1);
    vec_t t;
    t.flush = f; t.vld = v; t.pc = pc; t.deq = d; t.stall = s;
    t.e_cnt = c; t.e_rdy = r; t.e_vld = vl; t.e_pc0 = p0; t.e_pc1 = p1;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic f, input logic v, input logic [31:0] pc,
                       input logic [1:0] d, input logic s);
    flush_i         = f;
    fet_dec__vld_i  = v;
    fet_dec__data_i = mk(pc);
    dec_deq_cnt_i   = d;
    dec_stall_i     = s;
  endtask

  vec_t        tv [18];
  logic [31:0] mq [$];
  int          mc, d, pushed, popped, empty_c, full_c;

  initial begin
    tv[0]  = mkv(0, 1, 32'h1000, 0, 0, 0, 1, 2'b00, 0,        0);
    tv[1]  = mkv(0, 1, 32'h1004, 0, 0, 1, 1, 2'b01, 32'h1000, 0);
    tv[2]  = mkv(0, 1, 32'h1008, 0, 0, 2, 1, 2'b11, 32'h1000, 32'h1004);
    tv[3]  = mkv(0, 0, 32'h0,    0, 0, 3, 1, 2'b11, 32'h1000, 32'h1004);
    tv[4]  = mkv(0, 1, 32'h100C, 0, 0, 3, 1, 2'b11, 32'h1000, 32'h1004);
    tv[5]  = mkv(0, 1, 32'h1010, 2, 0, 4, 0, 2'b11, 32'h1000, 32'h1004);
    tv[6]  = mkv(0, 1, 32'h1010, 0, 0, 2, 1, 2'b11, 32'h1008, 32'h100C);
    tv[7]  = mkv(0, 1, 32'h2000, 1, 0, 3, 1, 2'b11, 32'h1008, 32'h100C);
    tv[8]  = mkv(0, 0, 32'h0,    2, 1, 3, 1, 2'b11, 32'h100C, 32'h1010);
    tv[9]  = mkv(0, 0, 32'h0,    2, 0, 3, 1, 2'b11, 32'h100C, 32'h1010);
    tv[10] = mkv(0, 0, 32'h0,    0, 0, 1, 1, 2'b01, 32'h2000, 0);
    tv[11] = mkv(0, 1, 32'h3000, 0, 0, 1, 1, 2'b01, 32'h2000, 0);
    tv[12] = mkv(0, 1, 32'h3004, 0, 0, 2, 1, 2'b11, 32'h2000, 32'h3000);
    tv[13] = mkv(1, 1, 32'h3008, 1, 0, 3, 1, 2'b00, 0,        0);
    tv[14] = mkv(0, 1, 32'h4000, 0, 0, 0, 1, 2'b00, 0,        0);
    tv[15] = mkv(0, 0, 32'h0,    0, 0, 1, 1, 2'b01, 32'h4000, 0);
    tv[16] = mkv(0, 0, 32'h0,    1, 0, 1, 1, 2'b01, 32'h4000, 0);
    tv[17] = mkv(0, 0, 32'h0,    0, 0, 0, 1, 2'b00, 0,        0);

    rst_i = 1'b1;
    drive(0, 0, 32'h0, 0, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    @(negedge clk_i);
    chk("reset_cnt",   128'(dec_cnt_o),          128'(3'd0));
    chk("reset_rdy",   128'(dec_fet__rdy_o),     128'(1'b1));
    chk("reset_vld",   128'(dec_slot_vld_o),     128'(2'b00));
    chk("reset_slot0", 128'(dec_slot_data_o[0]), 128'(0));
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 18; i++) begin
      drive(tv[i].flush, tv[i].vld, tv[i].pc, tv[i].deq, tv[i].stall);
      @(negedge clk_i);
      chk($sformatf("v%0d_cnt", i), 128'(dec_cnt_o),      128'(tv[i].e_cnt));
      chk($sformatf("v%0d_rdy", i), 128'(dec_fet__rdy_o), 128'(tv[i].e_rdy));
      chk($sformatf("v%0d_vld", i), 128'(dec_slot_vld_o), 128'(tv[i].e_vld));
      if (tv[i].e_vld[0])
        chk($sformatf("v%0d_slot0", i), 128'(dec_slot_data_o[0]), 128'(mk(tv[i].e_pc0)));
      if (tv[i].e_vld[1])
        chk($sformatf("v%0d_slot1_pc", i), 128'(dec_slot_data_o[1].pc), 128'(tv[i].e_pc1));
      @(posedge clk_i);
      #1;
    end

    // Asynchronous reset in the middle of a cycle with entries queued.
    drive(0, 1, 32'h5000, 0, 0);
    @(posedge clk_i);
    #1 drive(0, 1, 32'h5004, 0, 0);
    @(posedge clk_i);
    #1 drive(0, 0, 32'h0, 0, 0);
    @(negedge clk_i);
    chk("pre_rst_cnt", 128'(dec_cnt_o), 128'(3'd2));
    #2 rst_i = 1'b1;
    #1;
    chk("async_rst_cnt", 128'(dec_cnt_o),      128'(3'd0));
    chk("async_rst_vld", 128'(dec_slot_vld_o), 128'(2'b00));
    chk("async_rst_rdy", 128'(dec_fet__rdy_o), 128'(1'b1));
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Pointer wrap: 12 entries through 4 slots, alternating deq 1/2.
    pushed = 0; popped = 0; empty_c = 0; full_c = 0;
    for (int cyc = 0; cyc < 200 && popped < 12; cyc++) begin
      mc = mq.size();
      d  = (cyc % 2 == 0) ? 1 : 2;
      if (d > mc) d = mc;
      drive(0, pushed < 12, 32'h1000 + 32'(4 * pushed), 2'(d), 0);
      @(negedge clk_i);
      chk($sformatf("wrap%0d_cnt", cyc), 128'(dec_cnt_o),      128'(3'(mc)));
      chk($sformatf("wrap%0d_rdy", cyc), 128'(dec_fet__rdy_o), 128'(mc != 4));
      for (int k = 0; k < d; k++)
        chk($sformatf("wrap%0d_slot%0d_pc", cyc, k), 128'(dec_slot_data_o[k].pc), 128'(mq[k]));
      @(posedge clk_i);
      #1;
      if (mc == 0) empty_c++;
      if (mc == 4) full_c++;
      for (int k = 0; k < d; k++) begin
        void'(mq.pop_front());
        popped++;
      end
      if (pushed < 12 && mc != 4) begin
        mq.push_back(32'h1000 + 32'(4 * pushed));
        pushed++;
      end
    end
    if (popped != 12) begin
      failures++;
      $display("FAIL wrap_timeout actual=%0d required=12", popped);
    end
    chk("wrap_final_cnt", 128'(dec_cnt_o), 128'(3'd0));
`ifdef SY_DEC_QUEUE_PERF_EN
    chk("perf_empty", 128'(perf_empty_cyc_o), 128'(32'(empty_c)));
    chk("perf_full",  128'(perf_full_cyc_o),  128'(32'(full_c)));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sy_ppl_dec_queue
`default_nettype wire

// File: doc/sy_ppl_dec_queue.md
Name: sy_ppl_dec_queue

Overview:
- Parametrised successor of the single-entry fetch-to-decode holding register.
- A DEPTH-entry in-order instruction queue between the fetch stage and the decoder/rename stage.
- Accepts one fetched instruction per cycle and presents up to DEQ_W oldest entries per cycle for multi-wide decode.
- Supports partial dequeue, pipeline flush and rename/free-list back-pressure.

Parameters:
- DEPTH, 4: number of entries; power of 2; must be >= DEQ_W and >= 2.
- DEQ_W, 2: decode width, i.e. number of output slots; 1..4.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- flush_i  in  1  kill all queued entries and any same-cycle enqueue.
- fet_dec__vld_i  in  1  fetch entry valid.
- dec_fet__rdy_o  out  1  queue can accept an entry this cycle.
- fet_dec__data_i  in  dec_entry_t  {instr[IWTH], pc[AWTH], npc[AWTH], is_c, excp}.
- dec_slot_vld_o  out  DEQ_W  per-slot valid; slot 0 holds the oldest entry.
- dec_slot_data_o  out  DEQ_W x dec_entry_t  slot contents.
- dec_deq_cnt_i  in  $clog2(DEQ_W+1)  number of slots consumed this cycle; always the leading slots.
- dec_stall_i  in  1  downstream stall (free-list empty or dispatch not ready); forces the effective dequeue count to 0.
- dec_cnt_o  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage is a circular buffer with rd_ptr and wr_ptr ($clog2(DEPTH) bits each, natural wrap) and a count register.
- Reset: ptrs = 0, count = 0, all slot valids 0, dec_fet__rdy_o = 1, entry storage cleared to 0.
- dec_fet__rdy_o = (count != DEPTH). It is registered-state only; there is no combinational path from dec_deq_cnt_i.
- Enqueue fires when fet_dec__vld_i && dec_fet__rdy_o && !flush_i. It writes entry[wr_ptr] and increments wr_ptr.
- Output slots:
  - slot k shows entry[rd_ptr+k] (mod DEPTH).
  - dec_slot_vld_o[k] = (k < count) && !flush_i.
- Latency: an entry enqueued in cycle t is visible in slot 0 at t+1 at the earliest. There is no same-cycle bypass.
- Effective dequeue: deq = dec_stall_i ? 0 : dec_deq_cnt_i. deq > number of valid slots is a protocol error; flag it with an assertion and clamp deq to count.
- Dequeue advances rd_ptr by deq. The next count is count + enq - deq; simultaneous enqueue and dequeue in the same cycle are legal.
- Full case: with count == DEPTH, rdy is 0 even if a dequeue occurs in the same cycle. The slot frees next cycle.
- Empty case: with count == 0, all slot valids are 0 and any dec_deq_cnt_i is ignored.
- Flush has priority over everything:
  - next count = 0 and rd_ptr = wr_ptr = 0.
  - same-cycle enqueue and dequeue are discarded.
  - valids are 0 in the flush cycle.
  - rdy returns to 1 the following cycle.
- Reset asserted mid-operation clears state immediately (asynchronous). Outputs are valid-low until the first post-reset enqueue plus 1 cycle.
- In-order guarantee: slots never skip; partial dequeue leaves the remaining entries in order at the slot 0 position next cycle.

Optional Feature:
- Macro: SY_DEC_QUEUE_PERF_EN.
- When defined, the block adds output ports perf_empty_cyc_o [31:0] and perf_full_cyc_o [31:0].
  - These are saturating counters of cycles with count == 0 and count == DEPTH respectively.
  - Both are reset to 0 and are not affected by flush_i.
- When undefined, the ports and the counters are absent. The rest of the behaviour is identical.

Decomposition:
- sy_pkg gains:
  - typedef dec_entry_t {instr, pc, npc, is_c, excp}.
  - constant DEC_QUEUE_DEPTH = 4.
  - constant DEC_W = 2.
- Sub-module sy_ppl_dec_queue_mem: DEPTH x dec_entry_t register array with one write port and DEQ_W asynchronous read ports.
- Pointer and count control stays in the top module.

Test Plan:
- Reset, then push PCs 0x1000, 0x1004, 0x1008 on consecutive cycles with deq = 0 → count = 3; slot0 pc = 0x1000, slot1 pc = 0x1004; rdy = 1.
- Fill to DEPTH = 4 with deq = 0 → rdy = 0 and count = 4. Then deq = 2 with vld held → count = 2 next cycle, rdy = 1, and slot0 shows the third entry.
- With count = 3, drive deq = 1 and enqueue 0x2000 in the same cycle → count stays 3; slot0 advances by one; 0x2000 ends up last.
- dec_stall_i = 1 with dec_deq_cnt_i = 2 → no dequeue and count unchanged. Release the stall → count decreases by 2.
- flush_i asserted with count = 3 and a concurrent enqueue → slot valids = 0 in the same cycle; count = 0 next cycle; the enqueued entry is dropped; the next push appears at slot0.
- Push 12 entries through DEPTH = 4 with alternating deq 1/2 → pointer wrap preserves PC order 0x1000..0x102C with no loss or duplication. With SY_DEC_QUEUE_PERF_EN defined, the empty and full counters match the bench's count of empty and full cycles.
